apb_master_ctrl: RTL and testbench

- Parametrised APB4 master bridge: converts a simple valid/ready command port into APB SETUP/ACCESS transfers toward up to NUM_SLAVES slaves.
- Generalises the existing fixed 16-bit/32-bit, single-PSEL APB bus:
  - configurable address and data width
  - per-slave PSEL decode
  - muxed slave responses
  - back-to-back transfers
  - optional wait-state timeout
- Sits between an internal requester (CPU/DMA/test sequencer) and the APB slave fabric.

---
 rtl/apb_master_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_apb_master_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_ctrl.sv
// APB4 master bridge: valid/ready command port -> APB SETUP/ACCESS transfers to NUM_SLAVES slaves.
// Latency accept->rsp_valid: 3 cycles for a zero-wait slave, +1 per PREADY-low cycle; 2 for a decode error.
// Backpressure: cmd_ready only in IDLE and on the ACCESS completion cycle; the response port has none.
//
// Ports:
//   PCLOCK, PRESET                    clock (rising edge), asynchronous active-high reset
//   cmd_valid/cmd_ready, cmd_write,   command request; accepted when cmd_valid & cmd_ready
//   cmd_addr, cmd_wdata, cmd_strb, cmd_prot
//   rsp_valid, rsp_rdata, rsp_err     one-cycle completion pulse; data/err held until the next pulse
//   PADDR, PPROT, PSEL, PENABLE,      APB4 master outputs, one PSEL line per slave
//   PWRITE, PWDATA, PSTRB
//   PREADY, PRDATA, PSLVERR           per-slave APB inputs; slave i data at [i*DATA_WIDTH +: DATA_WIDTH]
//
// Optional feature: define APB_MASTER_TIMEOUT_EN to abandon an ACCESS phase after TIMEOUT_CYCLES
// PREADY-low cycles, completing it with rsp_err=1. Without it ACCESS waits indefinitely.
module apb_master_ctrl #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int SEL_LSB        = 12,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                           PCLOCK,
  input  logic                           PRESET,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic                           cmd_write,
  input  logic [ADDR_WIDTH-1:0]          cmd_addr,
  input  logic [DATA_WIDTH-1:0]          cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]        cmd_strb,
  input  logic [2:0]                     cmd_prot,
  output logic                           rsp_valid,
  output logic [DATA_WIDTH-1:0]          rsp_rdata,
  output logic                           rsp_err,
  output logic [ADDR_WIDTH-1:0]          PADDR,
  output logic [2:0]                     PPROT,
  output logic [NUM_SLAVES-1:0]          PSEL,
  output logic                           PENABLE,
  output logic                           PWRITE,
  output logic [DATA_WIDTH-1:0]          PWDATA,
  output logic [DATA_WIDTH/8-1:0]        PSTRB,
  input  logic [NUM_SLAVES-1:0]          PREADY,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]          PSLVERR
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_WIDTH  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  if (TIMEOUT_CYCLES < 1 || NUM_SLAVES < 1 || NUM_SLAVES > 16 || (DATA_WIDTH % 8) != 0) begin : g_bad_params
    $error("apb_master_ctrl: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DERR} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   idx_full;
  logic                    dec_ok;
  logic                    accept;
  logic                    in_xfer;
  logic                    timeout_hit;

  logic [IDX_WIDTH-1:0]    idx_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    write_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_WIDTH-1:0]   strb_q;
  logic [2:0]              prot_q;

  logic                    pready_sel;
  logic                    pslverr_sel;
  logic [DATA_WIDTH-1:0]   prdata_sel;

  // Slave index is the address bits above SEL_LSB; anything past the last slave is a decode error.
  assign idx_full = cmd_addr >> SEL_LSB;
  assign dec_ok   = (idx_full < ADDR_WIDTH'(NUM_SLAVES));
  assign accept   = cmd_valid & cmd_ready;

  // Only the captured slave's response lines are observed.
  assign pready_sel  = PREADY[idx_q];
  assign pslverr_sel = PSLVERR[idx_q];
  assign prdata_sel  = PRDATA[idx_q*DATA_WIDTH +: DATA_WIDTH];

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int WCNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  logic [WCNT_WIDTH-1:0] wcnt;

  always_ff @(posedge PCLOCK or posedge PRESET) begin
    if (PRESET) begin
      wcnt <= '0;
    end else if (state == SETUP) begin
      wcnt <= '0;
    end else if (state == ACCESS && !pready_sel) begin
      wcnt <= wcnt + 1'b1;
    end
  end

  // This PREADY-low cycle is the one that brings the count to TIMEOUT_CYCLES.
  assign timeout_hit = (state == ACCESS) && !pready_sel &&
                       (wcnt == WCNT_WIDTH'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge PCLOCK or posedge PRESET) begin
    if (PRESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_nxt = dec_ok ? SETUP : DERR;
        end
      end
      SETUP: begin
        state_nxt = ACCESS;
      end
      ACCESS: begin
        if (pready_sel) begin
          // Completion cycle doubles as an accept slot so transfers can run back to back.
          cmd_ready = 1'b1;
          if (cmd_valid) begin
            state_nxt = dec_ok ? SETUP : DERR;
          end else begin
            state_nxt = IDLE;
          end
        end else if (timeout_hit) begin
          state_nxt = IDLE;
        end
      end
      DERR: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (PRESET) begin
      cmd_ready = 1'b0;
    end
  end

  // Captured command; these registers also hold the bus values while idle.
  always_ff @(posedge PCLOCK or posedge PRESET) begin
    if (PRESET) begin
      idx_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      prot_q  <= '0;
    end else if (accept) begin
      idx_q   <= idx_full[IDX_WIDTH-1:0];
      addr_q  <= cmd_addr;
      write_q <= cmd_write;
      wdata_q <= cmd_wdata;
      strb_q  <= cmd_strb;
      prot_q  <= cmd_prot;
    end
  end

  assign in_xfer = (state == SETUP) || (state == ACCESS);

  always_comb begin
    PSEL = '0;
    if (in_xfer) begin
      PSEL[idx_q] = 1'b1;
    end
  end

  assign PENABLE = (state == ACCESS);
  assign PADDR   = addr_q;
  assign PWRITE  = write_q;
  assign PPROT   = prot_q;
  assign PWDATA  = wdata_q;
  assign PSTRB   = write_q ? strb_q : '0;

  always_ff @(posedge PCLOCK or posedge PRESET) begin
    if (PRESET) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (state == ACCESS && pready_sel) begin
        rsp_valid <= 1'b1;
        rsp_err   <= pslverr_sel;
        rsp_rdata <= (!write_q && !pslverr_sel) ? prdata_sel : '0;
      end else if (state == DERR || timeout_hit) begin
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b1;
        rsp_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Bench for apb_master_ctrl: randomized commands against a reference model, APB slaves emulated
// by a table-driven responder, responses checked by a queue-based monitor decoupled from stimulus.
module tb_apb_master_ctrl;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int NS = 4;
  localparam int SW = DW / 8;
  localparam int TO = 16;

  logic          PCLOCK = 1'b0;
  logic          PRESET;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_strb;
  logic [2:0]    cmd_prot;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] PADDR;
  logic [2:0]    PPROT;
  logic [NS-1:0] PSEL;
  logic          PENABLE, PWRITE;
  logic [DW-1:0] PWDATA;
  logic [SW-1:0] PSTRB;
  logic [NS-1:0] PREADY, PSLVERR;
  logic [NS*DW-1:0] PRDATA;

  apb_master_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS), .SEL_LSB(12),
                    .TIMEOUT_CYCLES(TO)) dut (
    .PCLOCK(PCLOCK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(PADDR), .PPROT(PPROT), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  always #5 PCLOCK = ~PCLOCK;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge PCLOCK) cyc <= cyc + 1;

  // Slave behaviour per word offset (addr[9:2]): wait cycles and error response.
  int          wait_tab [256];
  bit          err_tab  [256];
  logic [31:0] ref_mem  [NS][256];
  logic [31:0] bfm_mem  [NS][256];
  bit          stuck = 1'b0;   // slave 3 never raises PREADY while set

  typedef struct {
    bit          err;
    logic [31:0] rdata;
    int          acc;
    int          lat;
  } rsp_exp_t;

  typedef struct {
    logic [NS-1:0] sel;
    logic          wr;
    logic [15:0]   addr;
    logic [31:0]   wdata;
    logic [3:0]    strb;
    logic [2:0]    prot;
  } apb_exp_t;

  rsp_exp_t rsp_q[$];
  apb_exp_t apb_q[$];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void fail_now(input string name, input string what);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
  endfunction

  // Reference model: what an accepted command must produce on the bus and on the response port.
  task automatic model_accept(input logic w, input logic [15:0] a, input logic [31:0] d,
                              input logic [3:0] s, input logic [2:0] p, input int acc);
    rsp_exp_t r;
    apb_exp_t t;
    int idx, wi;
    idx   = int'(a[15:12]);
    wi    = int'(a[9:2]);
    r.acc = acc;
    if (idx >= NS) begin
      r.err = 1'b1; r.rdata = '0; r.lat = 2;
    end else if (stuck && idx == 3) begin
`ifdef APB_MASTER_TIMEOUT_EN
      r.err = 1'b1; r.rdata = '0; r.lat = 2 + TO;
`else
      return;
`endif
    end else begin
      r.lat = 3 + wait_tab[wi];
      r.err = err_tab[wi];
      if (w) begin
        r.rdata = '0;
        if (!r.err)
          for (int b = 0; b < 4; b++)
            if (s[b]) ref_mem[idx][wi][8*b +: 8] = d[8*b +: 8];
      end else begin
        r.rdata = r.err ? 32'h0 : ref_mem[idx][wi];
      end
      t.sel = '0; t.sel[idx] = 1'b1;
      t.wr = w; t.addr = a; t.wdata = d; t.strb = w ? s : 4'h0; t.prot = p;
      apb_q.push_back(t);
    end
    rsp_q.push_back(r);
  endtask

  // APB slave responder: unselected slaves drive random noise every cycle.
  int acc_cnt = 0;
  always @(negedge PCLOCK) begin : bfm
    apb_exp_t t;
    int idx, wi;
    logic e;
    PREADY  = NS'($urandom);
    PSLVERR = NS'($urandom);
    for (int i = 0; i < NS; i++) PRDATA[i*DW +: DW] = $urandom;
    if (PRESET || !PENABLE) begin
      acc_cnt = 0;
    end else begin
      idx = 0;
      for (int i = 0; i < NS; i++) if (PSEL[i]) idx = i;
      wi = int'(PADDR[9:2]);
      if (stuck && idx == 3) begin
        PREADY[idx] = 1'b0;
        acc_cnt++;
      end else if (acc_cnt >= wait_tab[wi]) begin
        e = err_tab[wi];
        PREADY[idx]  = 1'b1;
        PSLVERR[idx] = e;
        PRDATA[idx*DW +: DW] = bfm_mem[idx][wi];
        if (PWRITE && !e)
          for (int b = 0; b < 4; b++)
            if (PSTRB[b]) bfm_mem[idx][wi][8*b +: 8] = PWDATA[8*b +: 8];
        if (apb_q.size() == 0) begin
          fail_now("apb_transfer", "got an APB transfer, expected none");
        end else begin
          t = apb_q.pop_front();
          chk("apb_psel",   64'(PSEL),   64'(t.sel));
          chk("apb_paddr",  64'(PADDR),  64'(t.addr));
          chk("apb_pwrite", 64'(PWRITE), 64'(t.wr));
          chk("apb_pwdata", 64'(PWDATA), 64'(t.wdata));
          chk("apb_pstrb",  64'(PSTRB),  64'(t.strb));
          chk("apb_pprot",  64'(PPROT),  64'(t.prot));
        end
        acc_cnt = 0;
      end else begin
        PREADY[idx] = 1'b0;
        acc_cnt++;
      end
    end
  end

  // ACCESS must repeat the previous cycle's select, address and data.
  logic [NS-1:0] prev_sel  = '0;
  logic [15:0]   prev_addr = '0;
  logic [31:0]   prev_wd   = '0;
  always @(negedge PCLOCK) begin : proto
    if (!PRESET && PENABLE)
      chk("access_hold", 64'({PSEL != 0, PSEL, PADDR, PWDATA}),
          64'({1'b1, prev_sel, prev_addr, prev_wd}));
    prev_sel  = PRESET ? '0 : PSEL;
    prev_addr = PADDR;
    prev_wd   = PWDATA;
  end

  // Response monitor.
  always @(negedge PCLOCK) begin : mon
    rsp_exp_t r;
    if (!PRESET && rsp_valid) begin
      if (rsp_q.size() == 0) begin
        fail_now("rsp_unexpected", "got rsp_valid, expected none");
      end else begin
        r = rsp_q.pop_front();
        chk("rsp_err",     64'(rsp_err),      64'(r.err));
        chk("rsp_rdata",   64'(rsp_rdata),    64'(r.rdata));
        chk("rsp_latency", 64'(cyc - r.acc),  64'(r.lat));
      end
    end
  end

  // Called and returns at negedge+1; acceptance is sampled at negedge+2.
  task automatic issue(input logic w, input logic [15:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [2:0] p, input bit keep, output int acc);
    int n;
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strb = s; cmd_prot = p;
    cmd_valid = 1'b1;
    acc = -1;
    n = 0;
    #1;
    while (!cmd_ready && n < 100) begin
      @(negedge PCLOCK); #2;
      n++;
    end
    if (!cmd_ready) begin
      fail_now("cmd_accept", "cmd_ready never rose within 100 cycles");
      cmd_valid = 1'b0;
      return;
    end
    acc = cyc;
    model_accept(w, a, d, s, p, cyc);
    @(negedge PCLOCK); #1;
    if (!keep) cmd_valid = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin @(negedge PCLOCK); #1; end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (rsp_q.size() != 0 && n < 300) begin step(1); n++; end
    if (rsp_q.size() != 0) fail_now("drain", "responses still outstanding after 300 cycles");
    step(2);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation still running at 500000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int a1, a2, acc, idx_r, wi_r;
    bit keep, prev_keep;
    logic [15:0] a;

    for (int w = 0; w < 256; w++) begin
      wait_tab[w] = $urandom_range(0, 3);
      err_tab[w]  = ($urandom_range(0, 5) == 0);
      for (int s = 0; s < NS; s++) begin
        ref_mem[s][w] = $urandom;
        bfm_mem[s][w] = ref_mem[s][w];
      end
    end
    wait_tab[0] = 0; err_tab[0] = 1'b0;
    wait_tab[1] = 0; err_tab[1] = 1'b0;
    wait_tab[4] = 3; err_tab[4] = 1'b0;
    wait_tab[8] = 0; err_tab[8] = 1'b1;
    wait_tab[9] = 0; err_tab[9] = 1'b0;
    ref_mem[2][4] = 32'h1234_5678; bfm_mem[2][4] = 32'h1234_5678;

    PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_strb = '0; cmd_prot = '0;
    repeat (3) @(negedge PCLOCK);
    #1;
    chk("rst_psel",      64'(PSEL),      64'(0));
    chk("rst_penable",   64'(PENABLE),   64'(0));
    chk("rst_paddr",     64'(PADDR),     64'(0));
    chk("rst_pwdata",    64'(PWDATA),    64'(0));
    chk("rst_pstrb_pwr", 64'({PSTRB, PWRITE, PPROT}), 64'(0));
    chk("rst_rsp",       64'({rsp_valid, rsp_err, rsp_rdata}), 64'(0));
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    PRESET = 1'b0;
    step(1);

    // Zero-wait write to slave 1.
    issue(1'b1, 16'h1004, 32'hDEAD_BEEF, 4'hF, 3'd2, 1'b0, acc);
    chk("wr_setup_psel",    64'(PSEL),    64'(4'b0010));
    chk("wr_setup_penable", 64'(PENABLE), 64'(0));
    step(1);
    chk("wr_access_penable", 64'(PENABLE), 64'(1));
    chk("wr_access_pstrb",   64'(PSTRB),   64'(4'hF));
    step(1);

    // Read from slave 2 with three wait states.
    issue(1'b0, 16'h2010, 32'h0, 4'hF, 3'd0, 1'b0, acc);
    drain();

    // Back-to-back write then read.
    issue(1'b1, 16'h0000, 32'hA5A5_0001, 4'h3, 3'd1, 1'b1, a1);
    issue(1'b0, 16'h3000, 32'h0, 4'h0, 3'd0, 1'b0, a2);
    chk("b2b_accept_gap",   64'(a2 - a1), 64'(2));
    chk("b2b_setup_psel",   64'(PSEL),    64'(4'b1000));
    chk("b2b_setup_penable", 64'(PENABLE), 64'(0));
    step(1);
    chk("b2b_access_penable", 64'(PENABLE), 64'(1));
    drain();

    // Decode error.
    issue(1'b0, 16'h4000, 32'h0, 4'h0, 3'd0, 1'b0, acc);
    chk("derr_psel",    64'(PSEL),    64'(0));
    chk("derr_penable", 64'(PENABLE), 64'(0));
    drain();

    // Slave error followed by a clean access to the same slave.
    issue(1'b1, 16'h0020, 32'h1111_2222, 4'hF, 3'd0, 1'b0, acc);
    issue(1'b0, 16'h0024, 32'h0, 4'h0, 3'd0, 1'b0, acc);
    drain();

    // Randomized traffic, including decode errors and back-to-back bursts.
    prev_keep = 1'b0;
    for (int k = 0; k < 250; k++) begin
      if (!prev_keep) step($urandom_range(0, 2));
      idx_r = $urandom_range(0, 5);
      wi_r  = $urandom_range(0, 255);
      a     = {idx_r[3:0], 2'b00, wi_r[7:0], 2'b00};
      keep  = (k == 249) ? 1'b0 : 1'($urandom_range(0, 1));
      issue(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
            3'($urandom_range(0, 7)), keep, acc);
      prev_keep = keep;
    end
    drain();

    // Slave 3 never responds.
    stuck = 1'b1;
    issue(1'b0, 16'h3008, 32'h0, 4'h0, 3'd0, 1'b0, acc);
`ifdef APB_MASTER_TIMEOUT_EN
    drain();
    chk("timeout_psel",    64'(PSEL),    64'(0));
    chk("timeout_penable", 64'(PENABLE), 64'(0));
    stuck = 1'b0;
`else
    step(5);
    chk("stuck_psel",    64'(PSEL),    64'(4'b1000));
    chk("stuck_penable", 64'(PENABLE), 64'(1));
    #2;
    PRESET = 1'b1;
    #1;
    chk("midrst_psel",      64'(PSEL),      64'(0));
    chk("midrst_penable",   64'(PENABLE),   64'(0));
    chk("midrst_cmd_ready", 64'(cmd_ready), 64'(0));
    step(2);
    PRESET = 1'b0;
    stuck  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("postrst_no_rsp", 64'(rsp_valid), 64'(0));
    end
`endif

    // Normal operation after the abandoned transfer.
    issue(1'b0, 16'h1004, 32'h0, 4'h0, 3'd0, 1'b0, acc);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
